// File: rtl/fetcher_pkg.sv
// Shared types for the instruction fetch stage: address/instruction buses,
// the NOP encoding, fetch FSM states and cache geometry helpers.
package fetcher_pkg;

    typedef logic [31:0] inst_addr_t;
    typedef logic [31:0] inst_t;

    // addi x0, x0, 0
    localparam inst_t NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_OUT   = 2'd2
    } fetch_state_e;

    // Index bits select one word-sized entry; the two byte-offset bits are
    // never part of index or tag, so the cache works on word addresses.
    function automatic int icache_index_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int icache_tag_w(input int lines);
        return 30 - $clog2(lines);
    endfunction

endpackage

// File: rtl/fetcher_icache.sv
// Direct-mapped instruction cache, one instruction per entry.
// Combinational lookup port, synchronous write port. Only instantiated
// when FETCHER_ICACHE_EN is defined.
module icache
    import fetcher_pkg::*;
#(
    parameter int LINES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] rd_word,
    output logic        hit,
    output inst_t       rd_data,
    input  logic        wr_en,
    input  logic [29:0] wr_word,
    input  inst_t       wr_data
);

    localparam int IW = icache_index_w(LINES);
    localparam int TW = icache_tag_w(LINES);

    logic [LINES-1:0] valid;
    logic [TW-1:0]    tags [LINES];
    inst_t            data [LINES];

    logic [IW-1:0] rd_idx;
    logic [TW-1:0] rd_tag;
    logic [IW-1:0] wr_idx;
    logic [TW-1:0] wr_tag;

    assign rd_idx = rd_word[IW-1:0];
    assign rd_tag = rd_word[29:IW];
    assign wr_idx = wr_word[IW-1:0];
    assign wr_tag = wr_word[29:IW];

    // Valid bits: cleared by reset, set on fill, never invalidated otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // Tag/data storage written on fill.
    // NOTE: the arrays carry no reset; the valid bits alone decide whether an
    // entry means anything, which keeps the storage mappable to plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_idx] <= wr_tag;
            data[wr_idx] <= wr_data;
        end
    end

    assign hit     = valid[rd_idx] && (tags[rd_idx] == rd_tag);
    assign rd_data = data[rd_idx];

endmodule

// File: rtl/fetcher.sv
// Instruction fetch stage: holds the PC, fetches each instruction as four
// little-endian byte reads and hands {instPc, inst} to the decoder over a
// valid/ready handshake. A jump redirects the PC and discards any byte still
// in flight. Optional direct-mapped cache: define FETCHER_ICACHE_EN.
module fetcher
    import fetcher_pkg::*;
#(
    parameter inst_addr_t RESET_PC     = 32'h0000_0000,
    parameter int         ICACHE_LINES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jumpEn,
    input  logic [31:0] jumpAddr,
    output logic        memReq,
    output logic [31:0] memAddr,
    input  logic        memAck,
    input  logic        memDataValid,
    input  logic [7:0]  memData,
    output logic        instValid,
    input  logic        instReady,
    output logic [31:0] inst,
    output logic [31:0] instPc
);

    if (ICACHE_LINES < 2 || (ICACHE_LINES & (ICACHE_LINES - 1)) != 0) begin : g_bad_lines
        $error("ICACHE_LINES must be a power of two and at least 2");
    end

    fetch_state_e state, state_next;
    inst_addr_t   pc;
    logic [2:0]   req_cnt;     // bytes requested and acked, 0..4
    logic [1:0]   rsp_cnt;     // lane for the next returning byte
    logic         discard;     // drop the next returning byte
    logic         ack_prev;    // a request was accepted last cycle
    logic         req_acked;
    logic         take_byte;
    logic         last_byte;
    inst_t        word_next;
    logic         cache_hit;
    inst_t        cache_data;

    assign req_acked = memReq & memAck;
    assign take_byte = (state == ST_FETCH) && memDataValid && !discard && !jumpEn;
    assign last_byte = take_byte && (rsp_cnt == 2'd3);

    // Word with the returning byte merged into its lane.
    always_comb begin
        word_next = inst;
        word_next[{rsp_cnt, 3'b000} +: 8] = memData;
    end

`ifdef FETCHER_ICACHE_EN
    icache #(
        .LINES   (ICACHE_LINES)
    ) u_icache (
        .clk     (clk),
        .rst     (rst),
        .rd_word (pc[31:2]),
        .hit     (cache_hit),
        .rd_data (cache_data),
        .wr_en   (last_byte),
        .wr_word (pc[31:2]),
        .wr_data (word_next)
    );
`else
    assign cache_hit  = 1'b0;
    assign cache_data = NOP_INST;
`endif

    // FSM state register.
    // NOTE: sequential blocks use <= so every register updates from the
    // values present before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and memory/decoder-facing outputs; a jump overrides all.
    // NOTE: every output gets a default first so no path leaves one unassigned
    // and no latch is inferred.
    always_comb begin
        state_next = state;
        memReq     = 1'b0;
        memAddr    = '0;
        instValid  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                state_next = cache_hit ? ST_OUT : ST_FETCH;
            end
            ST_FETCH: begin
                if (req_cnt < 3'd4) begin
                    memReq  = 1'b1;
                    memAddr = pc + {29'd0, req_cnt};
                end
                if (last_byte) begin
                    state_next = ST_OUT;
                end
            end
            ST_OUT: begin
                instValid = 1'b1;
                if (instReady) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (jumpEn) begin
            state_next = ST_IDLE;
        end
    end

    // PC, counters, discard tracking and the output instruction register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            req_cnt  <= '0;
            rsp_cnt  <= '0;
            discard  <= 1'b0;
            ack_prev <= 1'b0;
            inst     <= NOP_INST;
            instPc   <= '0;
        end else begin
            ack_prev <= req_acked;
            if (jumpEn) begin
                pc      <= jumpAddr;
                req_cnt <= '0;
                rsp_cnt <= '0;
                // A byte is still owed if one was accepted now, or accepted
                // last cycle without its response showing up yet; a pending
                // flag survives until some byte arrives.
                discard <= req_acked
                         | (ack_prev & ~memDataValid)
                         | (discard & ~memDataValid);
            end else begin
                if (discard && memDataValid) begin
                    discard <= 1'b0;
                end
                unique case (state)
                    ST_IDLE: begin
                        if (cache_hit) begin
                            inst   <= cache_data;
                            instPc <= pc;
                        end
                    end
                    ST_FETCH: begin
                        if (req_acked) begin
                            req_cnt <= req_cnt + 3'd1;
                        end
                        if (take_byte) begin
                            inst    <= word_next;
                            rsp_cnt <= rsp_cnt + 2'd1;
                        end
                        if (last_byte) begin
                            instPc  <= pc;
                            req_cnt <= '0;
                        end
                    end
                    ST_OUT: begin
                        if (instReady) begin
                            pc <= pc + 32'd4;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
